// File: rtl/bp_axi_mem_responder.sv
// AXI4 slave backing-store memory for cosim (stands in for the PS DRAM port).
// Independent write (AW/W/B) and read (AR/R) engines share one word array.
// Only full-width INCR bursts are supported; burst/size are not ported.
//
// Ports:
//   clk_i, reset_n_i          clock, asynchronous active-low reset
//   s_axi_aw*  (in/out)       write address channel (addr, id, len, valid/ready)
//   s_axi_w*   (in/out)       write data channel (data, strb, last, valid/ready)
//   s_axi_b*   (in/out)       write response channel (id, resp, valid/ready)
//   s_axi_ar*  (in/out)       read address channel (addr, id, len, valid/ready)
//   s_axi_r*   (in/out)       read data channel (data, id, resp, last, valid/ready)
module bp_axi_mem_responder #(
    parameter int                      addr_width_p = 32,
    parameter int                      data_width_p = 64,
    parameter int                      id_width_p   = 6,
    parameter int                      mem_els_p    = 65536,
    parameter logic [addr_width_p-1:0] base_addr_p  = 32'h8000_0000
) (
    input  logic                      clk_i,
    input  logic                      reset_n_i,

    input  logic [addr_width_p-1:0]   s_axi_awaddr_i,
    input  logic [id_width_p-1:0]     s_axi_awid_i,
    input  logic [3:0]                s_axi_awlen_i,
    input  logic                      s_axi_awvalid_i,
    output logic                      s_axi_awready_o,

    input  logic [data_width_p-1:0]   s_axi_wdata_i,
    input  logic [data_width_p/8-1:0] s_axi_wstrb_i,
    input  logic                      s_axi_wlast_i,
    input  logic                      s_axi_wvalid_i,
    output logic                      s_axi_wready_o,

    output logic [id_width_p-1:0]     s_axi_bid_o,
    output logic [1:0]                s_axi_bresp_o,
    output logic                      s_axi_bvalid_o,
    input  logic                      s_axi_bready_i,

    input  logic [addr_width_p-1:0]   s_axi_araddr_i,
    input  logic [id_width_p-1:0]     s_axi_arid_i,
    input  logic [3:0]                s_axi_arlen_i,
    input  logic                      s_axi_arvalid_i,
    output logic                      s_axi_arready_o,

    output logic [data_width_p-1:0]   s_axi_rdata_o,
    output logic [id_width_p-1:0]     s_axi_rid_o,
    output logic [1:0]                s_axi_rresp_o,
    output logic                      s_axi_rlast_o,
    output logic                      s_axi_rvalid_o,
    input  logic                      s_axi_rready_i
);

    localparam int strb_width_lp = data_width_p / 8;
    localparam int off_bits_lp   = $clog2(strb_width_lp);
    localparam int idx_width_lp  = $clog2(mem_els_p);
    localparam logic [addr_width_p:0]   base_ext_lp = {1'b0, base_addr_p};
    localparam logic [addr_width_p:0]   els_ext_lp  = (addr_width_p + 1)'(mem_els_p);
    localparam logic [addr_width_p-1:0] step_lp     = addr_width_p'(strb_width_lp);

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
    typedef enum logic       {R_IDLE, R_DATA}         r_state_e;

    logic [data_width_p-1:0] mem [mem_els_p];

    // ---------------- write engine ----------------
    w_state_e                w_state;
    logic [addr_width_p-1:0] w_addr;
    logic [id_width_p-1:0]   w_id;
    logic [3:0]              w_len, w_cnt;
    logic                    w_err;
    logic                    aw_ready_r, w_ready_r, b_valid_r;
    logic [1:0]              b_resp_r;

    // Range check is done one bit wider so addresses below the base go negative
    logic [addr_width_p:0]   w_off, w_idx_full;
    logic [idx_width_lp-1:0] w_idx;
    logic                    w_in, w_fire, w_beat_err;

    assign w_off      = {1'b0, w_addr} - base_ext_lp;
    assign w_idx_full = w_off >> off_bits_lp;
    assign w_idx      = w_idx_full[idx_width_lp-1:0];
    assign w_in       = ({1'b0, w_addr} >= base_ext_lp) && (w_idx_full < els_ext_lp);
    assign w_fire     = w_ready_r && s_axi_wvalid_i;
    // wlast must coincide with the len-th beat; either mismatch direction is an error
    assign w_beat_err = !w_in || (s_axi_wlast_i != (w_cnt == w_len));

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            w_state    <= W_IDLE;
            w_addr     <= '0;
            w_id       <= '0;
            w_len      <= '0;
            w_cnt      <= '0;
            w_err      <= 1'b0;
            aw_ready_r <= 1'b0;
            w_ready_r  <= 1'b0;
            b_valid_r  <= 1'b0;
            b_resp_r   <= '0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (aw_ready_r && s_axi_awvalid_i) begin
                        w_addr     <= s_axi_awaddr_i;
                        w_id       <= s_axi_awid_i;
                        w_len      <= s_axi_awlen_i;
                        w_cnt      <= '0;
                        w_err      <= 1'b0;
                        aw_ready_r <= 1'b0;
                        w_ready_r  <= 1'b1;
                        w_state    <= W_DATA;
                    end else begin
                        aw_ready_r <= 1'b1;
                    end
                end
                W_DATA: begin
                    if (w_fire) begin
                        w_addr <= w_addr + step_lp;
                        w_cnt  <= w_cnt + 4'd1;
                        w_err  <= w_err | w_beat_err;
                        if (s_axi_wlast_i) begin
                            w_ready_r <= 1'b0;
                            b_valid_r <= 1'b1;
                            b_resp_r  <= (w_err || w_beat_err) ? 2'b10 : 2'b00;
                            w_state   <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (s_axi_bready_i) begin
                        b_valid_r  <= 1'b0;
                        b_resp_r   <= '0;
                        aw_ready_r <= 1'b1;
                        w_state    <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    // Memory is deliberately not reset
    always_ff @(posedge clk_i) begin
        if (w_fire && w_in) begin
            for (int unsigned b = 0; b < strb_width_lp; b++) begin
                if (s_axi_wstrb_i[b]) begin
                    mem[w_idx][8*b +: 8] <= s_axi_wdata_i[8*b +: 8];
                end
            end
        end
    end

    assign s_axi_awready_o = aw_ready_r;
    assign s_axi_wready_o  = w_ready_r;
    assign s_axi_bvalid_o  = b_valid_r;
    assign s_axi_bresp_o   = b_resp_r;
    assign s_axi_bid_o     = w_id;

    // ---------------- read engine ----------------
    r_state_e                r_state;
    logic [addr_width_p-1:0] r_addr;
    logic [id_width_p-1:0]   r_id;
    logic [3:0]              r_len, r_cnt;
    logic                    ar_ready_r, r_valid_r;

    logic [addr_width_p:0]   r_off, r_idx_full;
    logic [idx_width_lp-1:0] r_idx;
    logic                    r_in;

    assign r_off      = {1'b0, r_addr} - base_ext_lp;
    assign r_idx_full = r_off >> off_bits_lp;
    assign r_idx      = r_idx_full[idx_width_lp-1:0];
    assign r_in       = ({1'b0, r_addr} >= base_ext_lp) && (r_idx_full < els_ext_lp);

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state    <= R_IDLE;
            r_addr     <= '0;
            r_id       <= '0;
            r_len      <= '0;
            r_cnt      <= '0;
            ar_ready_r <= 1'b0;
            r_valid_r  <= 1'b0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (ar_ready_r && s_axi_arvalid_i) begin
                        r_addr     <= s_axi_araddr_i;
                        r_id       <= s_axi_arid_i;
                        r_len      <= s_axi_arlen_i;
                        r_cnt      <= '0;
                        ar_ready_r <= 1'b0;
                        r_valid_r  <= 1'b1;
                        r_state    <= R_DATA;
                    end else begin
                        ar_ready_r <= 1'b1;
                    end
                end
                R_DATA: begin
                    if (s_axi_rready_i) begin
                        r_addr <= r_addr + step_lp;
                        r_cnt  <= r_cnt + 4'd1;
                        if (r_cnt == r_len) begin
                            r_valid_r  <= 1'b0;
                            ar_ready_r <= 1'b1;
                            r_state    <= R_IDLE;
                        end
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    // Combinational array read: a same-cycle write to this word is seen next cycle
    assign s_axi_rdata_o   = (r_valid_r && r_in) ? mem[r_idx] : '0;
    assign s_axi_rresp_o   = (r_valid_r && !r_in) ? 2'b10 : 2'b00;
    assign s_axi_rlast_o   = r_valid_r && (r_cnt == r_len);
    assign s_axi_rvalid_o  = r_valid_r;
    assign s_axi_rid_o     = r_id;
    assign s_axi_arready_o = ar_ready_r;

endmodule
